// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program counter, branch resolution, LR/CTR ownership and
// post-branch fetch-flush window for the uPower single-issue core.
module branch_pc_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  CTR_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  FLUSH_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 instr_valid,
  input  logic                 stall,
  input  logic [5:0]           po,
  input  logic [9:0]           xo,
  input  logic                 aa,
  input  logic                 lk,
  input  logic [4:0]           bo,
  input  logic [4:0]           bi,
  input  logic [13:0]          bd,
  input  logic [23:0]          li,
  input  logic [31:0]          cr,
  input  logic                 lr_wr_en,
  input  logic                 ctr_wr_en,
  input  logic [CTR_WIDTH-1:0] spr_wr_data,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [CTR_WIDTH-1:0] lr,
  output logic [CTR_WIDTH-1:0] ctr,
  output logic                 taken,
  output logic                 flush
);

  typedef enum logic {RUN, FLUSH} state_t;

  // Displacements are widened to at least 24 bits before truncating to the
  // PC width, so narrow PCs still see correct modulo arithmetic.
  localparam int         EXT_W      = (PC_WIDTH > 24) ? PC_WIDTH : 24;
  localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 0);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t state, state_next;
  logic [3:0] count, count_next;

  logic                 is_b, is_bc, is_bclr, is_bcctr, is_branch;
  logic                 evaluate, cond_ok, ctr_ok, branch_taken;
  logic                 link_en, ctr_dec_en;
  logic [EXT_W-1:0]     li_wide, bd_wide;
  logic [PC_WIDTH-1:0]  li_ext, bd_ext, pc_plus1, target;
  logic [CTR_WIDTH-1:0] ctr_dec;

  assign is_b      = (po == 6'd18);
  assign is_bc     = (po == 6'd16);
  assign is_bclr   = (po == 6'd19) && (xo == 10'd16);
  assign is_bcctr  = (po == 6'd19) && (xo == 10'd528);
  assign is_branch = is_b | is_bc | is_bclr | is_bcctr;

  // Instructions are only acted on in RUN and while not stalled.
  assign evaluate = instr_valid & ~stall & (state == RUN);

  assign li_wide  = EXT_W'($signed(li));
  assign bd_wide  = EXT_W'($signed(bd));
  assign li_ext   = li_wide[PC_WIDTH-1:0];
  assign bd_ext   = bd_wide[PC_WIDTH-1:0];
  assign pc_plus1 = pc + PC_WIDTH'(1);

  // BO_0 is bo[4]; CR bit n lives at cr[31-n].
  assign cond_ok = bo[4] | (cr[5'd31 - bi] == bo[3]);
  assign ctr_dec = ctr - CTR_WIDTH'(1);
  assign ctr_ok  = bo[2] | ((ctr_dec != '0) ^ bo[1]);

  assign branch_taken = evaluate & (is_b |
                                    ((is_bc | is_bclr) & cond_ok & ctr_ok) |
                                    (is_bcctr & cond_ok));

  assign link_en    = evaluate & is_branch & lk;
  assign ctr_dec_en = evaluate & (is_bc | is_bclr) & ~bo[2];

  assign flush = (state == FLUSH);

  // Branch target selection; bclr uses the LR value from before any link write.
  always_comb begin
    target = pc_plus1;
    if (is_b)
      target = aa ? li_ext : (pc_plus1 + li_ext);
    else if (is_bc)
      target = aa ? bd_ext : (pc_plus1 + bd_ext);
    else if (is_bclr)
      target = lr[PC_WIDTH-1:0];
    else if (is_bcctr)
      target = ctr[PC_WIDTH-1:0];
  end

  // Architectural PC, LR, CTR and the taken pulse; SPR writes beat link/decrement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      lr    <= '0;
      ctr   <= '0;
      taken <= 1'b0;
    end else begin
      taken <= branch_taken;
      if (evaluate)
        pc <= branch_taken ? target : pc_plus1;
      if (!stall) begin
        if (lr_wr_en)
          lr <= spr_wr_data;
        else if (link_en)
          lr <= CTR_WIDTH'(pc_plus1);
        if (ctr_wr_en)
          ctr <= spr_wr_data;
        else if (ctr_dec_en)
          ctr <= ctr_dec;
      end
    end
  end

  // Flush FSM state register; reset aborts any open window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Flush FSM next state: open a window on a taken branch, count it down.
  always_comb begin
    state_next = state;
    count_next = count;
    if (!stall) begin
      case (state)
        RUN: begin
          if (branch_taken && FLUSH_EN) begin
            state_next = FLUSH;
            count_next = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (count <= 4'd1) begin
            state_next = RUN;
            count_next = 4'd0;
          end else begin
            count_next = count - 4'd1;
          end
        end
        default: begin
          state_next = RUN;
          count_next = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vectors for branch_pc_unit. Instance A is a
// 32-bit PC with a one-cycle flush; instance B is an 8-bit PC with a
// three-cycle flush. Each is held in reset while the other is exercised.
module tb_branch_pc_unit;

  logic        clock;
  logic        reset_a_n, reset_b_n;
  logic        instr_valid, stall;
  logic [5:0]  po;
  logic [9:0]  xo;
  logic        aa, lk;
  logic [4:0]  bo, bi;
  logic [13:0] bd;
  logic [23:0] li;
  logic [31:0] cr;
  logic        lr_wr_en, ctr_wr_en;
  logic [63:0] spr_wr_data;

  logic [31:0] a_pc;
  logic [63:0] a_lr, a_ctr;
  logic        a_taken, a_flush;
  logic [7:0]  b_pc;
  logic [15:0] b_lr, b_ctr;
  logic        b_taken, b_flush;

  int check_count = 0;
  int fail_count  = 0;

  branch_pc_unit #(
    .PC_WIDTH(32), .CTR_WIDTH(64), .RESET_PC(32'h10), .FLUSH_CYCLES(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_a_n), .instr_valid(instr_valid), .stall(stall),
    .po(po), .xo(xo), .aa(aa), .lk(lk), .bo(bo), .bi(bi), .bd(bd), .li(li),
    .cr(cr), .lr_wr_en(lr_wr_en), .ctr_wr_en(ctr_wr_en),
    .spr_wr_data(spr_wr_data),
    .pc(a_pc), .lr(a_lr), .ctr(a_ctr), .taken(a_taken), .flush(a_flush)
  );

  branch_pc_unit #(
    .PC_WIDTH(8), .CTR_WIDTH(16), .RESET_PC(8'hF0), .FLUSH_CYCLES(3)
  ) dut_b (
    .clock(clock), .reset_n(reset_b_n), .instr_valid(instr_valid), .stall(stall),
    .po(po), .xo(xo), .aa(aa), .lk(lk), .bo(bo), .bi(bi), .bd(bd), .li(li),
    .cr(cr), .lr_wr_en(lr_wr_en), .ctr_wr_en(ctr_wr_en),
    .spr_wr_data(spr_wr_data[15:0]),
    .pc(b_pc), .lr(b_lr), .ctr(b_ctr), .taken(b_taken), .flush(b_flush)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    instr_valid = 1'b0;
    po = '0; xo = '0; aa = 1'b0; lk = 1'b0;
    bo = '0; bi = '0; bd = '0; li = '0; cr = '0;
    lr_wr_en = 1'b0; ctr_wr_en = 1'b0; spr_wr_data = '0;
  endtask

  task automatic applyStimulus(input logic [5:0] p, input logic [9:0] x,
                               input logic a, input logic l,
                               input logic [4:0] o, input logic [4:0] i,
                               input logic [13:0] d, input logic [23:0] disp);
    po = p; xo = x; aa = a; lk = l; bo = o; bi = i; bd = d; li = disp;
    instr_valid = 1'b1;
    tick();
    clearInputs();
  endtask

  task automatic jumpA(input logic [23:0] addr);
    applyStimulus(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 14'd0, addr);
    tick();
  endtask

  initial begin
    clearInputs();
    stall = 1'b0;
    reset_a_n = 1'b0;
    reset_b_n = 1'b0;
    repeat (2) tick();

    checkOutput("rst_a_pc", a_pc, 64'h10);
    checkOutput("rst_a_lr", a_lr, 64'h0);
    checkOutput("rst_a_ctr", a_ctr, 64'h0);
    checkOutput("rst_a_flush", a_flush, 64'h0);
    checkOutput("rst_a_taken", a_taken, 64'h0);
    checkOutput("rst_b_pc", b_pc, 64'hF0);
    reset_a_n = 1'b1;
    tick();

    // Absolute b to 5, then bl -3 with link.
    applyStimulus(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 14'd0, 24'd5);
    checkOutput("b_abs_pc", a_pc, 64'd5);
    checkOutput("b_abs_taken", a_taken, 64'd1);
    checkOutput("b_abs_flush", a_flush, 64'd1);
    tick();
    checkOutput("b_abs_flush_end", a_flush, 64'd0);
    checkOutput("b_abs_taken_end", a_taken, 64'd0);

    applyStimulus(6'd18, 10'd0, 1'b0, 1'b1, 5'd0, 5'd0, 14'd0, 24'hFFFFFD);
    checkOutput("bl_pc", a_pc, 64'd3);
    checkOutput("bl_lr", a_lr, 64'd6);
    checkOutput("bl_taken", a_taken, 64'd1);
    checkOutput("bl_flush", a_flush, 64'd1);
    po = 6'd18; aa = 1'b1; lk = 1'b1; li = 24'd100; instr_valid = 1'b1;
    tick();
    clearInputs();
    checkOutput("flush_ignore_pc", a_pc, 64'd3);
    checkOutput("flush_ignore_lr", a_lr, 64'd6);
    checkOutput("flush_ignore_taken", a_taken, 64'd0);
    checkOutput("flush_one_cycle", a_flush, 64'd0);

    // bdnz loop with ctr=3 at pc=10.
    ctr_wr_en = 1'b1; spr_wr_data = 64'd3;
    tick();
    clearInputs();
    checkOutput("ctr_write", a_ctr, 64'd3);
    jumpA(24'd10);
    applyStimulus(6'd16, 10'd0, 1'b0, 1'b0, 5'b10000, 5'd0, 14'h3FFF, 24'd0);
    checkOutput("bdnz1_pc", a_pc, 64'd10);
    checkOutput("bdnz1_ctr", a_ctr, 64'd2);
    checkOutput("bdnz1_taken", a_taken, 64'd1);
    tick();
    applyStimulus(6'd16, 10'd0, 1'b0, 1'b0, 5'b10000, 5'd0, 14'h3FFF, 24'd0);
    checkOutput("bdnz2_pc", a_pc, 64'd10);
    checkOutput("bdnz2_ctr", a_ctr, 64'd1);
    tick();
    applyStimulus(6'd16, 10'd0, 1'b0, 1'b0, 5'b10000, 5'd0, 14'h3FFF, 24'd0);
    checkOutput("bdnz3_pc", a_pc, 64'd11);
    checkOutput("bdnz3_ctr", a_ctr, 64'd0);
    checkOutput("bdnz3_taken", a_taken, 64'd0);
    checkOutput("bdnz3_flush", a_flush, 64'd0);

    // CR-conditional branch on CR bit 2.
    jumpA(24'd20);
    cr = 32'h2000_0000;
    applyStimulus(6'd16, 10'd0, 1'b0, 1'b0, 5'b01100, 5'd2, 14'd4, 24'd0);
    checkOutput("cr_set_pc", a_pc, 64'd25);
    checkOutput("cr_set_ctr", a_ctr, 64'd0);
    checkOutput("cr_set_taken", a_taken, 64'd1);
    tick();
    jumpA(24'd20);
    cr = 32'hDFFF_FFFF;
    applyStimulus(6'd16, 10'd0, 1'b0, 1'b0, 5'b01100, 5'd2, 14'd4, 24'd0);
    checkOutput("cr_clr_pc", a_pc, 64'd21);
    checkOutput("cr_clr_flush", a_flush, 64'd0);
    checkOutput("cr_clr_taken", a_taken, 64'd0);

    // bclr with link, then with a simultaneous LR write.
    lr_wr_en = 1'b1; spr_wr_data = 64'd6;
    tick();
    clearInputs();
    jumpA(24'd40);
    applyStimulus(6'd19, 10'd16, 1'b0, 1'b1, 5'b10100, 5'd0, 14'd0, 24'd0);
    checkOutput("bclr_pc", a_pc, 64'd6);
    checkOutput("bclr_lr", a_lr, 64'd41);
    tick();
    jumpA(24'd40);
    lr_wr_en = 1'b1; spr_wr_data = 64'd6;
    tick();
    spr_wr_data = 64'd99;
    applyStimulus(6'd19, 10'd16, 1'b0, 1'b1, 5'b10100, 5'd0, 14'd0, 24'd0);
    checkOutput("bclr_prio_pc", a_pc, 64'd6);
    checkOutput("bclr_prio_lr", a_lr, 64'd99);
    tick();

    // bcctr uses the low PC bits of CTR and leaves CTR alone.
    ctr_wr_en = 1'b1; spr_wr_data = 64'h1_0000_0030;
    tick();
    clearInputs();
    applyStimulus(6'd19, 10'd528, 1'b0, 1'b0, 5'b10100, 5'd0, 14'd0, 24'd0);
    checkOutput("bcctr_pc", a_pc, 64'h30);
    checkOutput("bcctr_ctr", a_ctr, 64'h1_0000_0030);
    checkOutput("bcctr_taken", a_taken, 64'd1);
    tick();
    applyStimulus(6'd19, 10'd17, 1'b0, 1'b0, 5'b10100, 5'd0, 14'd0, 24'd0);
    checkOutput("xo_nonbranch_pc", a_pc, 64'h31);
    checkOutput("xo_nonbranch_taken", a_taken, 64'd0);

    // Asynchronous reset in the middle of a flush window.
    applyStimulus(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 14'd0, 24'd7);
    checkOutput("pre_reset_flush", a_flush, 64'd1);
    #2;
    reset_a_n = 1'b0;
    #1;
    checkOutput("async_rst_pc", a_pc, 64'h10);
    checkOutput("async_rst_lr", a_lr, 64'd0);
    checkOutput("async_rst_ctr", a_ctr, 64'd0);
    checkOutput("async_rst_flush", a_flush, 64'd0);

    // Instance B: 8-bit PC wrap and three-cycle flush with stall.
    reset_b_n = 1'b1;
    tick();
    checkOutput("b8_rst_pc", b_pc, 64'hF0);
    applyStimulus(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 14'd0, 24'h0000FF);
    checkOutput("b8_jump_pc", b_pc, 64'hFF);
    checkOutput("b8_flush_c1", b_flush, 64'd1);
    tick();
    checkOutput("b8_flush_c2", b_flush, 64'd1);
    tick();
    checkOutput("b8_flush_c3", b_flush, 64'd1);
    tick();
    checkOutput("b8_flush_done", b_flush, 64'd0);
    applyStimulus(6'd0, 10'd0, 1'b0, 1'b0, 5'd0, 5'd0, 14'd0, 24'd0);
    checkOutput("b8_wrap_pc", b_pc, 64'h00);

    applyStimulus(6'd18, 10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 14'd0, 24'h000040);
    checkOutput("b8_stall_jump_pc", b_pc, 64'h40);
    tick();
    checkOutput("b8_stall_pre", b_flush, 64'd1);
    stall = 1'b1;
    po = 6'd18; aa = 1'b1; li = 24'd5; instr_valid = 1'b1;
    lr_wr_en = 1'b1; spr_wr_data = 64'h1234;
    for (int s = 0; s < 2; s++) begin
      tick();
      checkOutput("b8_stall_flush", b_flush, 64'd1);
      checkOutput("b8_stall_pc", b_pc, 64'h40);
      checkOutput("b8_stall_lr", b_lr, 64'd0);
      checkOutput("b8_stall_taken", b_taken, 64'd0);
    end
    stall = 1'b0;
    clearInputs();
    tick();
    checkOutput("b8_post_stall_flush", b_flush, 64'd1);
    tick();
    checkOutput("b8_post_stall_done", b_flush, 64'd0);
    applyStimulus(6'd18, 10'd0, 1'b0, 1'b0, 5'd0, 5'd0, 14'd0, 24'hFFFFB0);
    checkOutput("b8_rel_wrap_pc", b_pc, 64'hF1);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
